int_dispatch_ctrl: RTL and testbench

INT_DISPATCH_CTRL -- requirements
Module: int_dispatch_ctrl

---
 rtl/int_dispatch_ctrl_if.sv | 15 +
 rtl/int_dispatch_ctrl.sv | 70 +++++++
 tb/tb_int_dispatch_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/int_dispatch_ctrl_if.sv
// int_dispatch_ctrl_if: CPU-side request, mask, enable and dispatch signals of the interrupt dispatcher
interface int_dispatch_ctrl_if #(parameter int NUM_IRQ = 5);
  logic [NUM_IRQ-1:0] irq_in, if_wdata, ie_wdata, if_q, ie_q;
  logic if_wr, ie_wr, ime_set, ime_clr, fetch;
  logic ime, wake, busy, push, vec_valid;
  logic [7:0] vector;
  modport master (
    output irq_in, if_wr, if_wdata, ie_wr, ie_wdata, ime_set, ime_clr, fetch,
    input if_q, ie_q, ime, wake, busy, push, vec_valid, vector
  );
  modport slave (
    input irq_in, if_wr, if_wdata, ie_wr, ie_wdata, ime_set, ime_clr, fetch,
    output if_q, ie_q, ime, wake, busy, push, vec_valid, vector
  );
endinterface

// File: rtl/int_dispatch_ctrl.sv
// int_dispatch_ctrl: edge-latched requests, EI-delayed master enable and five-cycle vectored dispatch
module int_dispatch_ctrl #(
  parameter int NUM_IRQ = 5,
  parameter logic [7:0] VEC_BASE = 8'h40,
  parameter logic [7:0] VEC_STRIDE = 8'h08
) (
  input logic clk,
  input logic nreset,
  int_dispatch_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT0, WAIT1, PUSH_HI, PUSH_LO, JUMP} state_t;
  state_t state_q, state_d;
  logic [NUM_IRQ-1:0] flag_q, flag_d, en_q, en_d, prev_q, rise, pend, sel;
  logic ime_q, ime_d, ei_q, ei_d, start, sample;
  logic [2:0] idx;
  logic [7:0] vec_q, vec_d;
  assign rise = bus.irq_in & ~prev_q;
  assign pend = flag_q & en_q;
  assign start = state_q == IDLE && bus.fetch && ime_q && |pend;
  assign sample = state_q == PUSH_LO;
  // descending scan so the lowest pending index is the one left standing
  always_comb begin
    idx = '0;
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        idx = 3'(i);
        sel = '0;
        sel[i] = 1'b1;
      end
    end
  end
  // a fresh edge is OR-ed in last so it beats both the software write and the dispatch clear
  assign flag_d = ((bus.if_wr ? bus.if_wdata : flag_q) & ~(sample ? sel : '0)) | rise;
  assign en_d = bus.ie_wr ? bus.ie_wdata : en_q;
  assign ime_d = (bus.ime_clr || start) ? 1'b0 : (ei_q && bus.fetch) ? 1'b1 : ime_q;
  assign ei_d = (bus.ime_clr || start) ? 1'b0 : bus.ime_set ? 1'b1 : bus.fetch ? 1'b0 : ei_q;
  assign vec_d = sample ? (|pend ? VEC_BASE + VEC_STRIDE * {5'b0, idx} : 8'h00) : vec_q;
  always_comb begin
    state_d = state_q == IDLE ? (start ? WAIT0 : IDLE) :
              state_q == JUMP ? IDLE : state_t'(state_q + 3'd1);
    bus.busy = state_q != IDLE;
    bus.push = state_q == PUSH_HI || state_q == PUSH_LO;
    bus.vec_valid = state_q == JUMP;
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      flag_q <= '0;
      en_q <= '0;
      prev_q <= '1;
      ime_q <= 1'b0;
      ei_q <= 1'b0;
      vec_q <= 8'h00;
    end else begin
      state_q <= state_d;
      flag_q <= flag_d;
      en_q <= en_d;
      prev_q <= bus.irq_in;
      ime_q <= ime_d;
      ei_q <= ei_d;
      vec_q <= vec_d;
    end
  end
  assign bus.if_q = flag_q;
  assign bus.ie_q = en_q;
  assign bus.ime = ime_q;
  assign bus.wake = |pend;
  assign bus.vector = vec_q;
endmodule

// File: tb/tb_int_dispatch_ctrl.sv
// tb_int_dispatch_ctrl: directed checks of int_dispatch_ctrl with a vector scoreboard
module tb_int_dispatch_ctrl;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] sb[$];
  int_dispatch_ctrl_if #(.NUM_IRQ(5)) bus();
  int_dispatch_ctrl #(.NUM_IRQ(5)) dut (.clk(clk), .nreset(nreset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_ime();
    bus.ime_set = 1'b1;
    tick();
    bus.ime_set = 1'b0;
    bus.fetch = 1'b1;
    tick();
    bus.fetch = 1'b0;
    chk("arm_ime", 32'(bus.ime), 1);
  endtask

  task automatic start_dispatch(input logic [7:0] v, input bit expect_jump);
    if (expect_jump) sb.push_back(v);
    bus.fetch = 1'b1;
    tick();
    bus.fetch = 1'b0;
    chk("start_busy", 32'(bus.busy), 1);
  endtask

  task automatic wait_jump();
    int n = 0;
    while (!bus.vec_valid && n < 8) begin
      tick();
      n++;
    end
    chk("jump_reached", 32'(bus.vec_valid), 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.vec_valid) begin
      if (sb.size() == 0) chk("vec_unexpected", 32'(bus.vector), 32'hFFFF_FFFF);
      else chk("vector", 32'(bus.vector), 32'(sb.pop_front()));
    end
  end

  initial begin
    {bus.irq_in, bus.if_wdata, bus.ie_wdata} = '0;
    {bus.if_wr, bus.ie_wr, bus.ime_set, bus.ime_clr, bus.fetch} = '0;
    #12;
    chk("rst_if_q", 32'(bus.if_q), 0);
    chk("rst_ie_q", 32'(bus.ie_q), 0);
    chk("rst_ime", 32'(bus.ime), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_push", 32'(bus.push), 0);
    chk("rst_vec", 32'(bus.vector), 0);
    tick();
    nreset = 1'b1;
    tick();
    // basic dispatch of source 0
    bus.ie_wr = 1'b1;
    bus.ie_wdata = 5'h01;
    bus.ime_set = 1'b1;
    tick();
    bus.ie_wr = 1'b0;
    bus.ime_set = 1'b0;
    chk("ie_load", 32'(bus.ie_q), 32'h01);
    chk("ime_armed_only", 32'(bus.ime), 0);
    bus.fetch = 1'b1;
    tick();
    bus.fetch = 1'b0;
    chk("ime_rise", 32'(bus.ime), 1);
    bus.irq_in = 5'h01;
    tick();
    chk("if_edge", 32'(bus.if_q), 32'h01);
    chk("wake", 32'(bus.wake), 1);
    chk("idle_busy", 32'(bus.busy), 0);
    start_dispatch(8'h40, 1'b1);
    chk("w0_ime", 32'(bus.ime), 0);
    chk("w0_push", 32'(bus.push), 0);
    tick();
    chk("w1_push", 32'(bus.push), 0);
    tick();
    chk("phi_push", 32'(bus.push), 1);
    tick();
    chk("plo_push", 32'(bus.push), 1);
    chk("plo_vv", 32'(bus.vec_valid), 0);
    tick();
    chk("jump_vv", 32'(bus.vec_valid), 1);
    chk("jump_busy", 32'(bus.busy), 1);
    chk("jump_if_q", 32'(bus.if_q), 0);
    tick();
    chk("after_busy", 32'(bus.busy), 0);
    chk("after_vv", 32'(bus.vec_valid), 0);
    chk("vec_hold", 32'(bus.vector), 32'h40);
    bus.irq_in = 5'h00;
    // priority: lowest enabled pending wins
    bus.ie_wr = 1'b1;
    bus.ie_wdata = 5'h1F;
    bus.if_wr = 1'b1;
    bus.if_wdata = 5'h14;
    tick();
    bus.ie_wr = 1'b0;
    bus.if_wr = 1'b0;
    chk("prio_if_q", 32'(bus.if_q), 32'h14);
    arm_ime();
    start_dispatch(8'h50, 1'b1);
    wait_jump();
    chk("prio_if_after", 32'(bus.if_q), 32'h10);
    tick();
    // cancellation by an IF write in WAIT1
    bus.if_wr = 1'b1;
    bus.if_wdata = 5'h04;
    tick();
    bus.if_wr = 1'b0;
    chk("cancel_if_q", 32'(bus.if_q), 32'h04);
    arm_ime();
    start_dispatch(8'h00, 1'b1);
    tick();
    bus.if_wr = 1'b1;
    bus.if_wdata = 5'h00;
    tick();
    bus.if_wr = 1'b0;
    chk("cancel_cleared", 32'(bus.if_q), 0);
    wait_jump();
    chk("cancel_if_after", 32'(bus.if_q), 0);
    tick();
    // EI delay and DI priority
    bus.ime_set = 1'b1;
    tick();
    bus.ime_set = 1'b0;
    chk("ei_d1", 32'(bus.ime), 0);
    tick();
    chk("ei_d2", 32'(bus.ime), 0);
    bus.fetch = 1'b1;
    tick();
    bus.fetch = 1'b0;
    chk("ei_fetch", 32'(bus.ime), 1);
    bus.ime_clr = 1'b1;
    tick();
    bus.ime_clr = 1'b0;
    chk("di_clear", 32'(bus.ime), 0);
    bus.ime_set = 1'b1;
    bus.ime_clr = 1'b1;
    tick();
    bus.ime_set = 1'b0;
    bus.ime_clr = 1'b0;
    bus.fetch = 1'b1;
    tick();
    bus.fetch = 1'b0;
    chk("di_wins", 32'(bus.ime), 0);
    bus.ime_set = 1'b1;
    tick();
    bus.ime_set = 1'b0;
    bus.ime_clr = 1'b1;
    tick();
    bus.ime_clr = 1'b0;
    bus.fetch = 1'b1;
    tick();
    bus.fetch = 1'b0;
    chk("di_disarms", 32'(bus.ime), 0);
    // hardware edge beats a same-cycle IF write; no dispatch without ime
    bus.irq_in = 5'h08;
    bus.if_wr = 1'b1;
    bus.if_wdata = 5'h00;
    tick();
    bus.if_wr = 1'b0;
    chk("collide_if_q", 32'(bus.if_q), 32'h08);
    chk("collide_wake", 32'(bus.wake), 1);
    chk("collide_ime", 32'(bus.ime), 0);
    bus.fetch = 1'b1;
    repeat (3) tick();
    bus.fetch = 1'b0;
    chk("no_ime_no_busy", 32'(bus.busy), 0);
    // new edge on the selected bit at the sampling edge keeps it set
    arm_ime();
    start_dispatch(8'h58, 1'b1);
    bus.irq_in = 5'h00;
    repeat (3) tick();
    chk("edge_plo_push", 32'(bus.push), 1);
    bus.irq_in = 5'h08;
    tick();
    chk("edge_jump_vv", 32'(bus.vec_valid), 1);
    chk("edge_keeps_bit", 32'(bus.if_q), 32'h08);
    tick();
    // asynchronous reset in PUSH_LO
    arm_ime();
    start_dispatch(8'h00, 1'b0);
    repeat (3) tick();
    chk("rst_at_plo", 32'(bus.push), 1);
    bus.irq_in = 5'h1F;
    nreset = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_push", 32'(bus.push), 0);
    chk("arst_vv", 32'(bus.vec_valid), 0);
    chk("arst_if_q", 32'(bus.if_q), 0);
    chk("arst_ie_q", 32'(bus.ie_q), 0);
    chk("arst_ime", 32'(bus.ime), 0);
    chk("arst_vec", 32'(bus.vector), 0);
    repeat (2) tick();
    nreset = 1'b1;
    repeat (2) tick();
    chk("release_no_edge", 32'(bus.if_q), 0);
    chk("release_busy", 32'(bus.busy), 0);
    bus.irq_in = 5'h1D;
    tick();
    bus.irq_in = 5'h1F;
    tick();
    chk("post_reset_edge", 32'(bus.if_q), 32'h02);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
